mul: RTL



---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_step.sv | 16 +
 rtl/mul.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative multiplier.
// The digit width NBIT_MUL follows the same convention as the divider's NBIT_DIV.
package mul_pkg;

    localparam int NBIT_MUL = 4;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_EXEC,
        MUL_OKAY
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One radix-2^NBIT shift-add step: adds mcand * digit to the upper accumulator half.
// The sum is wide enough that it cannot overflow: (2^X-1)*2^N < 2^(X+N).
module mul_step #(
    parameter int XLEN = 64,
    parameter int NBIT = 4
) (
    input  logic [XLEN-1:0]      acc_hi,
    input  logic [XLEN-1:0]      mcand,
    input  logic [NBIT-1:0]      digit,
    output logic [XLEN+NBIT-1:0] sum
);

    assign sum = {{NBIT{1'b0}}, acc_hi}
               + ({{NBIT{1'b0}}, mcand} * {{XLEN{1'b0}}, digit});

endmodule

// File: rtl/mul.sv
// Iterative sign-magnitude multiplier: operands are reduced to magnitudes, multiplied
// NBIT_MUL bits per cycle, and the 2*XLEN product is negated at the end if needed.
module mul
    import mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              trig,
    input  logic              flush,
    input  logic              signed1,
    input  logic [XLEN-1:0]   src1,
    input  logic              signed2,
    input  logic [XLEN-1:0]   src2,
    output logic [2*XLEN-1:0] out,
    output logic              okay
);

    localparam int STEPS = XLEN / NBIT_MUL;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    mul_state_e          state_q, state_d;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   p_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   out_q;

    logic                neg1, neg2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                skip;
    logic [2*XLEN-1:0]   skip_res;
    logic                accept;
    logic                last;
    logic [XLEN+NBIT_MUL-1:0] sum;
    logic [2*XLEN-1:0]   p_next;
    logic [2*XLEN-1:0]   res_final;

    // Negating the most-negative value yields 2^(XLEN-1), which is the correct magnitude
    // when read as unsigned.
    assign neg1 = signed1 & src1[XLEN-1];
    assign neg2 = signed2 & src2[XLEN-1];
    assign mag1 = neg1 ? (~src1 + XLEN'(1)) : src1;
    assign mag2 = neg2 ? (~src2 + XLEN'(1)) : src2;

    assign skip = (src1 == '0) || (src2 == '0) || (src2 == XLEN'(1));

    always_comb begin
        skip_res = '0;
        if ((src1 != '0) && (src2 != '0)) begin
            skip_res = signed1 ? {{XLEN{src1[XLEN-1]}}, src1} : {{XLEN{1'b0}}, src1};
        end
    end

    assign accept = (state_q == MUL_IDLE) && trig && !flush;
    assign last   = (cnt_q == '0);

    mul_step #(
        .XLEN (XLEN),
        .NBIT (NBIT_MUL)
    ) u_step (
        .acc_hi (p_q[2*XLEN-1:XLEN]),
        .mcand  (mcand_q),
        .digit  (p_q[NBIT_MUL-1:0]),
        .sum    (sum)
    );

    assign p_next    = {sum, p_q[XLEN-1:NBIT_MUL]};
    assign res_final = neg_q ? (~p_next + (2*XLEN)'(1)) : p_next;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: begin
                if (!flush && trig) begin
                    state_d = skip ? MUL_OKAY : MUL_EXEC;
                end
            end
            MUL_EXEC: begin
                if (flush || last) begin
                    state_d = MUL_OKAY;
                end
            end
            MUL_OKAY: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, so out/okay can never show X and an
    // operation interrupted by reset leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= MUL_IDLE;
            mcand_q <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (skip) begin
                    out_q <= skip_res;
                end else begin
                    mcand_q <= mag1;
                    p_q     <= {{XLEN{1'b0}}, mag2};
                    neg_q   <= neg1 ^ neg2;
                    cnt_q   <= CNT_W'(STEPS - 1);
                end
            end else if (state_q == MUL_EXEC && !flush) begin
                p_q <= p_next;
                if (last) begin
                    out_q <= res_final;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign out  = out_q;
    assign okay = (state_q == MUL_OKAY);

endmodule
